// File: rtl/cu_pkg.sv
// Shared constants, control bundle and decode helper for the pipelined control unit.
package cu_pkg;

    localparam logic [1:0] MODE_COMP = 2'b00;
    localparam logic [1:0] MODE_MEM  = 2'b01;
    localparam logic [1:0] MODE_BR   = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] EXE_NONE = 4'b0000;
    localparam logic [3:0] EXE_MOV  = 4'b0001;
    localparam logic [3:0] EXE_ADD  = 4'b0010;
    localparam logic [3:0] EXE_ADC  = 4'b0011;
    localparam logic [3:0] EXE_SUB  = 4'b0100;
    localparam logic [3:0] EXE_SBC  = 4'b0101;
    localparam logic [3:0] EXE_AND  = 4'b0110;
    localparam logic [3:0] EXE_ORR  = 4'b0111;
    localparam logic [3:0] EXE_EOR  = 4'b1000;
    localparam logic [3:0] EXE_MVN  = 4'b1001;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       mem_read;
        logic       mem_write;
        logic       wb_en;
        logic       b;
        logic       update_sr;
        logic       illegal;
    } ctl_t;

    // Map mode/op_code/S to the control bundle; anything unlisted is flagged illegal with no enables.
    function automatic ctl_t decode(input logic [1:0] mode, input logic [3:0] op_code, input logic s);
        ctl_t c;
        c = '0;
        case (mode)
            MODE_COMP: begin
                c.wb_en     = 1'b1;
                c.update_sr = s;
                case (op_code)
                    OP_MOV: c.exe_cmd = EXE_MOV;
                    OP_MVN: c.exe_cmd = EXE_MVN;
                    OP_ADD: c.exe_cmd = EXE_ADD;
                    OP_ADC: c.exe_cmd = EXE_ADC;
                    OP_SUB: c.exe_cmd = EXE_SUB;
                    OP_SBC: c.exe_cmd = EXE_SBC;
                    OP_AND: c.exe_cmd = EXE_AND;
                    OP_ORR: c.exe_cmd = EXE_ORR;
                    OP_EOR: c.exe_cmd = EXE_EOR;
                    OP_CMP: begin
                        c.exe_cmd   = EXE_SUB;
                        c.wb_en     = 1'b0;
                        c.update_sr = 1'b1;
                    end
                    OP_TST: begin
                        c.exe_cmd   = EXE_AND;
                        c.wb_en     = 1'b0;
                        c.update_sr = 1'b1;
                    end
                    default: begin
                        c         = '0;
                        c.illegal = 1'b1;
                    end
                endcase
            end
            MODE_MEM: begin
                if (op_code == OP_ADD) begin
                    c.exe_cmd = EXE_ADD;
                    if (s) begin
                        c.mem_read = 1'b1;
                        c.wb_en    = 1'b1;
                    end else begin
                        c.mem_write = 1'b1;
                    end
                end else begin
                    c.illegal = 1'b1;
                end
            end
            MODE_BR: c.b = 1'b1;
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-field evaluation against {N,Z,C,V}.
module cond_check (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);
    import cu_pkg::*;

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    // Select the pass bit for the condition code; NV never passes.
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// ID-stage control unit: decode, condition check, flag-hazard interlock and a DEPTH-stage
// control pipeline with stall/flush. Optional branch-shadow squash: CU_BRANCH_SHADOW_EN.
module pipelined_control_unit #(
    parameter int DEPTH     = 1,
    parameter int SR_LAT    = 2,
    parameter int BR_SHADOW = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  valid_in,
    input  logic [3:0]                            cond,
    input  logic [1:0]                            mode,
    input  logic [3:0]                            op_code,
    input  logic                                  S,
    input  logic [3:0]                            sr_flags,
    input  logic                                  sr_wr,
    input  logic                                  stall_in,
    input  logic                                  flush,
    output logic                                  ready_out,
    output logic                                  valid_out,
    output logic [3:0]                            exe_cmd,
    output logic                                  mem_read,
    output logic                                  mem_write,
    output logic                                  wb_en,
    output logic                                  b,
    output logic                                  update_sr,
    output logic                                  illegal,
    output logic [$clog2(DEPTH+SR_LAT+1)-1:0]     sr_pending
);
    import cu_pkg::*;

    localparam int PW   = $clog2(DEPTH + SR_LAT + 1);
    localparam int PMAX = (1 << PW) - 1;

    // Clamp the pending-writer count into its register range instead of wrapping.
    function automatic logic [PW-1:0] sat_pending(input int value);
        if (value < 0)
            return '0;
        else if (value > PMAX)
            return PW'(PMAX);
        else
            return PW'(value);
    endfunction

    ctl_t dec_ctl;
    ctl_t ctl_p0, ctl_p1, ctl_p2;
    ctl_t ctl_last, ctl_out;
    logic vld_p0, vld_p1, vld_p2, vld_last;
    logic cond_pass, hazard, accept, squash, load_vld, inc;
    int   flush_cnt, pend_sum;

    assign dec_ctl = decode(mode, op_code, S);

    cond_check u_cond (
        .cond  (cond),
        .flags (sr_flags),
        .pass  (cond_pass)
    );

    assign hazard    = valid_in && (cond != COND_AL) && (sr_pending != '0);
    assign ready_out = !stall_in && !flush && !hazard;
    assign accept    = valid_in && ready_out;
    assign load_vld  = accept && cond_pass && !squash;
    assign inc       = load_vld && dec_ctl.update_sr;

`ifdef CU_BRANCH_SHADOW_EN
    logic [1:0] shadow_cnt;
    assign squash = (shadow_cnt != 2'd0);

    // Count down the slots behind a taken branch; each accepted slot is nulled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            shadow_cnt <= 2'd0;
        else if (flush)
            shadow_cnt <= 2'd0;
        else if (accept) begin
            if (squash)
                shadow_cnt <= shadow_cnt - 2'd1;
            else if (dec_ctl.b && cond_pass)
                shadow_cnt <= 2'(BR_SHADOW);
        end
    end
`else
    logic br_shadow_unused;
    assign squash           = 1'b0;
    assign br_shadow_unused = ^BR_SHADOW;
`endif

    // Count live flag writers in the stages a flush discards, then form the next pending count.
    always_comb begin
        flush_cnt = 0;
        if (vld_p0 && ctl_p0.update_sr)
            flush_cnt = flush_cnt + 1;
        if (DEPTH > 1 && vld_p1 && ctl_p1.update_sr)
            flush_cnt = flush_cnt + 1;
        if (DEPTH > 2 && vld_p2 && ctl_p2.update_sr)
            flush_cnt = flush_cnt + 1;
        pend_sum = int'(sr_pending) + (inc ? 1 : 0) - (sr_wr ? 1 : 0) - (flush ? flush_cnt : 0);
    end

    // Pending flag-writer counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sr_pending <= '0;
        else
            sr_pending <= sat_pending(pend_sum);
    end

    // Stage valids: flush beats stall, stall holds, otherwise shift in the new valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (flush) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (!stall_in) begin
            vld_p0 <= load_vld;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // Stage control bundles: data only, qualified by the matching stage valid.
    always_ff @(posedge clk) begin
        if (!stall_in) begin
            ctl_p0 <= dec_ctl;
            ctl_p1 <= ctl_p0;
            ctl_p2 <= ctl_p1;
        end
    end

    // Tap the last configured stage and force a bubble to all-zero outputs.
    always_comb begin
        vld_last = vld_p0;
        ctl_last = ctl_p0;
        if (DEPTH == 2) begin
            vld_last = vld_p1;
            ctl_last = ctl_p1;
        end else if (DEPTH >= 3) begin
            vld_last = vld_p2;
            ctl_last = ctl_p2;
        end
        ctl_out = vld_last ? ctl_last : '0;
    end

    assign valid_out = vld_last;
    assign exe_cmd   = ctl_out.exe_cmd;
    assign mem_read  = ctl_out.mem_read;
    assign mem_write = ctl_out.mem_write;
    assign wb_en     = ctl_out.wb_en;
    assign b         = ctl_out.b;
    assign update_sr = ctl_out.update_sr;
    assign illegal   = ctl_out.illegal;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: one DEPTH=1 and one DEPTH=3 instance on shared inputs.
module tb_pipelined_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic [3:0] cond = 4'b1110;
    logic [1:0] mode = 2'b00;
    logic [3:0] op_code = 4'b0000;
    logic       S = 1'b0;
    logic [3:0] sr_flags = 4'b0000;
    logic       sr_wr = 1'b0;
    logic       stall_in = 1'b0;
    logic       flush = 1'b0;

    logic       ready_1, valid_1, mem_read_1, mem_write_1, wb_en_1, b_1, update_sr_1, illegal_1;
    logic [3:0] exe_cmd_1;
    logic [1:0] sr_pending_1;
    logic       ready_3, valid_3, mem_read_3, mem_write_3, wb_en_3, b_3, update_sr_3, illegal_3;
    logic [3:0] exe_cmd_3;
    logic [2:0] sr_pending_3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_control_unit #(.DEPTH(1), .SR_LAT(2), .BR_SHADOW(1)) u_d1 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .cond(cond), .mode(mode), .op_code(op_code),
        .S(S), .sr_flags(sr_flags), .sr_wr(sr_wr), .stall_in(stall_in), .flush(flush),
        .ready_out(ready_1), .valid_out(valid_1), .exe_cmd(exe_cmd_1), .mem_read(mem_read_1),
        .mem_write(mem_write_1), .wb_en(wb_en_1), .b(b_1), .update_sr(update_sr_1),
        .illegal(illegal_1), .sr_pending(sr_pending_1)
    );

    pipelined_control_unit #(.DEPTH(3), .SR_LAT(2), .BR_SHADOW(1)) u_d3 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .cond(cond), .mode(mode), .op_code(op_code),
        .S(S), .sr_flags(sr_flags), .sr_wr(sr_wr), .stall_in(stall_in), .flush(flush),
        .ready_out(ready_3), .valid_out(valid_3), .exe_cmd(exe_cmd_3), .mem_read(mem_read_3),
        .mem_write(mem_write_3), .wb_en(wb_en_3), .b(b_3), .update_sr(update_sr_3),
        .illegal(illegal_3), .sr_pending(sr_pending_3)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] m, input logic [3:0] op, input logic s, input logic [3:0] c);
        valid_in = 1'b1;
        mode     = m;
        op_code  = op;
        S        = s;
        cond     = c;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        #2;
        check("rst_valid", 8'(valid_1), 8'h0);
        check("rst_wb", 8'(wb_en_1), 8'h0);
        check("rst_pend", 8'(sr_pending_1), 8'h0);
        check("rst_valid3", 8'(valid_3), 8'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ADDS, DEPTH=1
        issue(2'b00, 4'b0100, 1'b1, 4'b1110);
        #1 check("add_ready", 8'(ready_1), 8'h1);
        step();
        valid_in = 1'b0;
        check("add_valid", 8'(valid_1), 8'h1);
        check("add_exe", 8'(exe_cmd_1), 8'h2);
        check("add_wb", 8'(wb_en_1), 8'h1);
        check("add_usr", 8'(update_sr_1), 8'h1);
        check("add_pend", 8'(sr_pending_1), 8'h1);
        step();
        check("bubble_valid", 8'(valid_1), 8'h0);
        check("bubble_exe", 8'(exe_cmd_1), 8'h0);

        // CMP (AL, no hazard) then BEQ interlocked until both writes commit
        issue(2'b00, 4'b1010, 1'b0, 4'b1110);
        #1 check("cmp_ready", 8'(ready_1), 8'h1);
        step();
        check("cmp_exe", 8'(exe_cmd_1), 8'h4);
        check("cmp_wb", 8'(wb_en_1), 8'h0);
        check("cmp_usr", 8'(update_sr_1), 8'h1);
        check("cmp_pend", 8'(sr_pending_1), 8'h2);
        issue(2'b10, 4'b0000, 1'b0, 4'b0000);
        #1 check("beq_hazard", 8'(ready_1), 8'h0);
        step();
        check("beq_held_valid", 8'(valid_1), 8'h0);
        check("beq_held_pend", 8'(sr_pending_1), 8'h2);
        sr_wr = 1'b1;
        step();
        check("srwr1_pend", 8'(sr_pending_1), 8'h1);
        check("srwr1_ready", 8'(ready_1), 8'h0);
        sr_flags = 4'b0100;
        step();
        sr_wr = 1'b0;
        check("srwr2_pend", 8'(sr_pending_1), 8'h0);
        #1 check("beq_ready", 8'(ready_1), 8'h1);
        step();
        check("beq_valid", 8'(valid_1), 8'h1);
        check("beq_b", 8'(b_1), 8'h1);
        check("beq_wb", 8'(wb_en_1), 8'h0);

        // MOV in the branch shadow, then a second MOV
        issue(2'b00, 4'b1101, 1'b0, 4'b1110);
        step();
`ifdef CU_BRANCH_SHADOW_EN
        check("shadow_null_valid", 8'(valid_1), 8'h0);
        check("shadow_null_exe", 8'(exe_cmd_1), 8'h0);
`else
        check("mov1_valid", 8'(valid_1), 8'h1);
        check("mov1_exe", 8'(exe_cmd_1), 8'h1);
`endif
        step();
        check("mov2_valid", 8'(valid_1), 8'h1);
        check("mov2_exe", 8'(exe_cmd_1), 8'h1);
        check("mov2_usr", 8'(update_sr_1), 8'h0);

        // LDR then a 3-cycle stall with another instruction waiting
        issue(2'b01, 4'b0100, 1'b1, 4'b1110);
        step();
        check("ldr_rd", 8'(mem_read_1), 8'h1);
        check("ldr_wr", 8'(mem_write_1), 8'h0);
        check("ldr_exe", 8'(exe_cmd_1), 8'h2);
        issue(2'b00, 4'b0100, 1'b0, 4'b1110);
        stall_in = 1'b1;
        #1 check("stall_ready", 8'(ready_1), 8'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", 8'(valid_1), 8'h1);
            check("stall_rd", 8'(mem_read_1), 8'h1);
            check("stall_wb", 8'(wb_en_1), 8'h1);
        end
        stall_in = 1'b0;
        valid_in = 1'b0;
        step();
        check("unstall_valid", 8'(valid_1), 8'h0);

        // STR
        issue(2'b01, 4'b0100, 1'b0, 4'b1110);
        step();
        check("str_wr", 8'(mem_write_1), 8'h1);
        check("str_wb", 8'(wb_en_1), 8'h0);

        // ADDS with NE while Z=1: accepted, nulled, no pending increment
        issue(2'b00, 4'b0100, 1'b1, 4'b0001);
        #1 check("ne_ready", 8'(ready_1), 8'h1);
        step();
        valid_in = 1'b0;
        check("ne_valid", 8'(valid_1), 8'h0);
        check("ne_pend", 8'(sr_pending_1), 8'h0);

        // Reserved mode and an unlisted compute opcode
        issue(2'b11, 4'b0000, 1'b0, 4'b1110);
        step();
        check("rsvd_illegal", 8'(illegal_1), 8'h1);
        check("rsvd_wb", 8'(wb_en_1), 8'h0);
        check("rsvd_b", 8'(b_1), 8'h0);
        check("rsvd_exe", 8'(exe_cmd_1), 8'h0);
        issue(2'b00, 4'b0011, 1'b1, 4'b1110);
        step();
        valid_in = 1'b0;
        check("undef_illegal", 8'(illegal_1), 8'h1);
        check("undef_usr", 8'(update_sr_1), 8'h0);
        check("undef_pend", 8'(sr_pending_1), 8'h0);

        // Asynchronous reset mid-stream
        issue(2'b00, 4'b0100, 1'b1, 4'b1110);
        step();
        valid_in = 1'b0;
        check("pre_rst_valid", 8'(valid_1), 8'h1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 8'(valid_1), 8'h0);
        check("async_rst_wb", 8'(wb_en_1), 8'h0);
        check("async_rst_exe", 8'(exe_cmd_1), 8'h0);
        check("async_rst_pend", 8'(sr_pending_1), 8'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // DEPTH=3: two flag writers in flight, then flush
        issue(2'b00, 4'b0100, 1'b1, 4'b1110);
        step();
        issue(2'b00, 4'b1010, 1'b0, 4'b1110);
        step();
        valid_in = 1'b0;
        check("d3_pend2", 8'(sr_pending_3), 8'h2);
        check("d3_not_yet", 8'(valid_3), 8'h0);
        flush = 1'b1;
        #1 check("d3_flush_ready", 8'(ready_3), 8'h0);
        step();
        flush = 1'b0;
        check("d3_flush_valid", 8'(valid_3), 8'h0);
        check("d3_flush_pend", 8'(sr_pending_3), 8'h0);
        step();
        check("d3_flush_after", 8'(valid_3), 8'h0);

        // DEPTH=3 latency
        issue(2'b00, 4'b1101, 1'b0, 4'b1110);
        step();
        valid_in = 1'b0;
        check("d3_lat1", 8'(valid_3), 8'h0);
        step();
        check("d3_lat2", 8'(valid_3), 8'h0);
        step();
        check("d3_lat3_valid", 8'(valid_3), 8'h1);
        check("d3_lat3_exe", 8'(exe_cmd_3), 8'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
